// File: rtl/video_modulator_subcarrier_gen.sv
// video_modulator_subcarrier_gen
// Colour subcarrier generator: a free-running 24-bit phase accumulator drives a
// 64-entry quarter-wave sine ROM, producing |sin| / |cos| magnitudes plus sign
// bits for a downstream unsigned multiplier. A per-line FSM opens the colour
// burst window (180 deg burst phase) and the active-video chroma window.
// Two-stage pipeline: phase -> ROM address/sign register -> output register.
// Optional build macro: VIDEO_MODULATOR_PAL_SWITCH_EN adds a line-parity flop
// that inverts cos_neg on odd lines (PAL V-axis switch).
module video_modulator_subcarrier_gen #(
    parameter logic [23:0] PHASE_INC   = 24'd2402192,
    parameter logic [9:0]  BURST_START = 10'd76,
    parameter logic [9:0]  BURST_LEN   = 10'd63
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       color_en,
    input  logic       line_start,
    input  logic       active,
    output logic [7:0] sin_mag_8,
    output logic [7:0] cos_mag_8,
    output logic       sin_neg,
    output logic       cos_neg,
    output logic       burst,
    output logic       chroma_valid
);

    // Last line-counter value spent in BURST; the counter runs from line_start.
    localparam logic [9:0] BURST_LAST = BURST_START + BURST_LEN - 10'd1;
    localparam logic [9:0] CNT_MAX    = 10'd1023;

    // Quarter-wave table: round(255*sin((i+0.5)*pi/128)), i = 0..63.
    localparam logic [7:0] SINE_ROM [0:63] = '{
        8'd3,   8'd9,   8'd16,  8'd22,  8'd28,  8'd34,  8'd41,  8'd47,
        8'd53,  8'd59,  8'd65,  8'd71,  8'd77,  8'd83,  8'd89,  8'd95,
        8'd100, 8'd106, 8'd112, 8'd117, 8'd123, 8'd128, 8'd134, 8'd139,
        8'd144, 8'd149, 8'd154, 8'd159, 8'd164, 8'd169, 8'd174, 8'd178,
        8'd183, 8'd187, 8'd191, 8'd195, 8'd199, 8'd203, 8'd207, 8'd210,
        8'd214, 8'd217, 8'd220, 8'd223, 8'd226, 8'd229, 8'd232, 8'd234,
        8'd237, 8'd239, 8'd241, 8'd243, 8'd245, 8'd247, 8'd248, 8'd249,
        8'd251, 8'd252, 8'd253, 8'd253, 8'd254, 8'd255, 8'd255, 8'd255
    };

    typedef enum logic [2:0] {
        IDLE       = 3'd0,
        PRE_BURST  = 3'd1,
        BURST      = 3'd2,
        POST_BURST = 3'd3,
        ACTIVE     = 3'd4
    } line_state_t;

    line_state_t state_reg, state_next;
    logic [9:0]  cnt_reg;
    logic [23:0] phase_reg;

    // FSM decoded windows (already qualified by color_en)
    logic burst_on;
    logic chroma_on;
    logic mag_on;

    // Stage-1 combinational inputs
    logic [1:0] quad;
    logic [5:0] rom_idx;
    logic [5:0] sin_idx_next;
    logic [5:0] cos_idx_next;
    logic       sin_neg_next;
    logic       cos_neg_next;
    logic       pal_flip;

    // Stage-1 registers (ROM address / sign)
    logic [5:0] sin_idx_reg;
    logic [5:0] cos_idx_reg;
    logic       sin_neg_s1_reg;
    logic       cos_neg_s1_reg;
    logic       burst_s1_reg;
    logic       chroma_s1_reg;
    logic       mag_on_s1_reg;

    // Stage-2 registers (outputs)
    logic [7:0] sin_mag_reg;
    logic [7:0] cos_mag_reg;
    logic       sin_neg_reg;
    logic       cos_neg_reg;
    logic       burst_reg;
    logic       chroma_valid_reg;

    // Phase accumulator: free-running, wraps modulo 2^24
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) phase_reg <= '0;
        else        phase_reg <= phase_reg + PHASE_INC;
    end

    // Line counter: cleared by line_start, counts while a line is in progress, saturates
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)                                      cnt_reg <= '0;
        else if (line_start)                             cnt_reg <= '0;
        else if (state_reg != IDLE && cnt_reg != CNT_MAX) cnt_reg <= cnt_reg + 10'd1;
    end

    // FSM state register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_reg <= IDLE;
        else        state_reg <= state_next;
    end

    // FSM next-state: line_start wins over every other condition
    always_comb begin
        state_next = state_reg;
        if (line_start) begin
            state_next = PRE_BURST;
        end else begin
            unique case (state_reg)
                PRE_BURST:  if (cnt_reg == BURST_START - 10'd1) state_next = BURST;
                BURST:      if (cnt_reg == BURST_LAST)          state_next = POST_BURST;
                POST_BURST: if (active)                         state_next = ACTIVE;
                ACTIVE:     if (!active)                        state_next = IDLE;
                default:                                        state_next = state_reg;
            endcase
        end
    end

    // FSM outputs: burst / chroma windows, both gated by color_en
    always_comb begin
        burst_on  = 1'b0;
        chroma_on = 1'b0;
        if (color_en) begin
            burst_on  = (state_reg == BURST);
            chroma_on = (state_reg == ACTIVE);
        end
        mag_on = burst_on | chroma_on;
    end

`ifdef VIDEO_MODULATOR_PAL_SWITCH_EN
    logic parity_reg;

    // Line parity: toggles on every line_start, odd lines flip the cos sign
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)          parity_reg <= 1'b0;
        else if (line_start) parity_reg <= ~parity_reg;
    end

    assign pal_flip = parity_reg;
`else
    assign pal_flip = 1'b0;
`endif

    assign quad    = phase_reg[23:22];
    assign rom_idx = phase_reg[21:16];

    // Quadrant folding: mirror the index in odd quadrants, cos uses the complement.
    // Burst carries 180 deg phase, so both signs are inverted there.
    always_comb begin
        sin_idx_next = quad[0] ? ~rom_idx : rom_idx;
        cos_idx_next = ~sin_idx_next;
        sin_neg_next = mag_on & (quad[1] ^ burst_on);
        cos_neg_next = mag_on & (quad[1] ^ quad[0] ^ burst_on ^ pal_flip);
    end

    // Stage 1: ROM address and sign register, window flags travel alongside
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sin_idx_reg    <= '0;
            cos_idx_reg    <= '0;
            sin_neg_s1_reg <= 1'b0;
            cos_neg_s1_reg <= 1'b0;
            burst_s1_reg   <= 1'b0;
            chroma_s1_reg  <= 1'b0;
            mag_on_s1_reg  <= 1'b0;
        end else begin
            sin_idx_reg    <= sin_idx_next;
            cos_idx_reg    <= cos_idx_next;
            sin_neg_s1_reg <= sin_neg_next;
            cos_neg_s1_reg <= cos_neg_next;
            burst_s1_reg   <= burst_on;
            chroma_s1_reg  <= chroma_on;
            mag_on_s1_reg  <= mag_on;
        end
    end

    // Stage 2: registered ROM read; magnitudes forced to 0 outside the windows
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sin_mag_reg      <= '0;
            cos_mag_reg      <= '0;
            sin_neg_reg      <= 1'b0;
            cos_neg_reg      <= 1'b0;
            burst_reg        <= 1'b0;
            chroma_valid_reg <= 1'b0;
        end else begin
            sin_mag_reg      <= mag_on_s1_reg ? SINE_ROM[sin_idx_reg] : 8'd0;
            cos_mag_reg      <= mag_on_s1_reg ? SINE_ROM[cos_idx_reg] : 8'd0;
            sin_neg_reg      <= sin_neg_s1_reg;
            cos_neg_reg      <= cos_neg_s1_reg;
            burst_reg        <= burst_s1_reg;
            chroma_valid_reg <= chroma_s1_reg;
        end
    end

    assign sin_mag_8    = sin_mag_reg;
    assign cos_mag_8    = cos_mag_reg;
    assign sin_neg      = sin_neg_reg;
    assign cos_neg      = cos_neg_reg;
    assign burst        = burst_reg;
    assign chroma_valid = chroma_valid_reg;

endmodule

// File: tb/tb_video_modulator_subcarrier_gen.sv
// tb_video_modulator_subcarrier_gen
// Three instances share clock and controls: default parameters (timing, reset,
// colour-off), PHASE_INC=0x400000 (quadrant stepping) and PHASE_INC=0x010000
// (one ROM entry per clock, used by the vector table).
module tb_video_modulator_subcarrier_gen;

    localparam logic [23:0] INC_D = 24'd2402192;
`ifdef VIDEO_MODULATOR_PAL_SWITCH_EN
    localparam bit PAL = 1'b1;
`else
    localparam bit PAL = 1'b0;
`endif

    logic clk;
    logic rst_n;
    logic color_en;
    logic line_start;
    logic active;

    logic [7:0] d_sin_mag, d_cos_mag, q_sin_mag, q_cos_mag, t_sin_mag, t_cos_mag;
    logic d_sin_neg, d_cos_neg, d_burst, d_chroma;
    logic q_sin_neg, q_cos_neg, q_burst, q_chroma;
    logic t_sin_neg, t_cos_neg, t_burst, t_chroma;
    logic [19:0] d_all;

    assign d_all = {d_sin_mag, d_cos_mag, d_sin_neg, d_cos_neg, d_burst, d_chroma};

    video_modulator_subcarrier_gen u_dut (
        .clk(clk), .rst_n(rst_n), .color_en(color_en), .line_start(line_start), .active(active),
        .sin_mag_8(d_sin_mag), .cos_mag_8(d_cos_mag), .sin_neg(d_sin_neg), .cos_neg(d_cos_neg),
        .burst(d_burst), .chroma_valid(d_chroma)
    );

    video_modulator_subcarrier_gen #(.PHASE_INC(24'h400000)) u_q (
        .clk(clk), .rst_n(rst_n), .color_en(color_en), .line_start(line_start), .active(active),
        .sin_mag_8(q_sin_mag), .cos_mag_8(q_cos_mag), .sin_neg(q_sin_neg), .cos_neg(q_cos_neg),
        .burst(q_burst), .chroma_valid(q_chroma)
    );

    video_modulator_subcarrier_gen #(.PHASE_INC(24'h010000)) u_t (
        .clk(clk), .rst_n(rst_n), .color_en(color_en), .line_start(line_start), .active(active),
        .sin_mag_8(t_sin_mag), .cos_mag_8(t_cos_mag), .sin_neg(t_sin_neg), .cos_neg(t_cos_neg),
        .burst(t_burst), .chroma_valid(t_chroma)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Clock edges since reset release; phase after edge k is k*PHASE_INC
    int unsigned cyc;
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) cyc <= 0;
        else        cyc <= cyc + 1;
    end

    typedef struct {
        int         n;
        logic [7:0] smag;
        logic [7:0] cmag;
        logic       sneg;
        logic       cneg;
    } vec_t;

    vec_t       tbl [9];
    logic       qs_sn [4];
    logic       qs_cn [4];
    logic [7:0] qs_sm [4];
    logic [7:0] qs_cm [4];

    int  n_cmp, n_bad;
    int  rise, hi, q;
    bit  par;
    logic sa, ca, sb, cb, nz;
    logic [7:0]  ta, tbm;
    logic [23:0] ph0, dph;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d (0x%0h) required %0d (0x%0h) at cyc %0d", name, act, act, exp, exp, cyc);
        end else begin
            $display("ok   %s = %0d at cyc %0d", name, act, cyc);
        end
    endtask

    task automatic step();
        @(negedge clk);
    endtask

    // Pulse line_start for one clock; returns at the negedge after the sampling edge
    task automatic pulse_line();
        line_start = 1'b1;
        @(negedge clk);
        line_start = 1'b0;
        par = par ^ PAL;
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish, %0d compared", n_cmp);
        $fatal(1, "watchdog");
    end

    initial begin
        n_cmp = 0; n_bad = 0; par = 1'b0;
        rst_n = 1'b0; color_en = 1'b0; line_start = 1'b0; active = 1'b0;

        // phase -> expected outputs for the 0x010000 instance (n = phase[23:16])
        tbl[0] = '{0,   8'd3,   8'd255, 1'b0, 1'b0};
        tbl[1] = '{10,  8'd65,  8'd247, 1'b0, 1'b0};
        tbl[2] = '{40,  8'd214, 8'd139, 1'b0, 1'b0};
        tbl[3] = '{63,  8'd255, 8'd3,   1'b0, 1'b0};
        tbl[4] = '{64,  8'd255, 8'd3,   1'b0, 1'b1};
        tbl[5] = '{100, 8'd159, 8'd199, 1'b0, 1'b1};
        tbl[6] = '{130, 8'd16,  8'd255, 1'b1, 1'b1};
        tbl[7] = '{200, 8'd249, 8'd53,  1'b1, 1'b0};
        tbl[8] = '{255, 8'd3,   8'd255, 1'b1, 1'b0};

        // quadrant 0..3 with index 0 (0x400000 instance)
        qs_sn = '{1'b0, 1'b0, 1'b1, 1'b1};
        qs_cn = '{1'b0, 1'b1, 1'b1, 1'b0};
        qs_sm = '{8'd3, 8'd255, 8'd3, 8'd255};
        qs_cm = '{8'd255, 8'd3, 8'd255, 8'd3};

        // Reset state
        repeat (3) step();
        chk("reset_outputs", 32'(d_all), 32'd0);
        chk("reset_state", 32'(u_dut.state_reg), 32'd0);
        chk("reset_phase", 32'(u_dut.phase_reg), 32'd0);
        rst_n = 1'b1; color_en = 1'b1; active = 1'b1;
        repeat (10) step();
        chk("idle_outputs", 32'(d_all), 32'd0);
        chk("idle_state", 32'(u_dut.state_reg), 32'd0);
        chk("idle_phase", 32'(u_dut.phase_reg), 32'((cyc * 32'(INC_D)) & 32'hFFFFFF));
        active = 1'b0;

        // Burst timing and burst-phase signs
        pulse_line();
        rise = 0; hi = 0;
        for (int t = 0; t <= 160; t++) begin
            if (d_burst && rise == 0) rise = t;
            if (d_burst) hi++;
            if (t == 50) chk("preburst_zero", 32'({d_sin_mag, d_cos_mag, d_burst}), 32'd0);
            if (t == 100) begin
                q = int'((cyc - 2) & 32'd3);
                chk("burst_sin_neg", 32'(q_sin_neg), 32'(qs_sn[q] ^ 1'b1));
                chk("burst_cos_neg", 32'(q_cos_neg), 32'(qs_cn[q] ^ 1'b1 ^ par));
                chk("burst_sin_mag", 32'(q_sin_mag), 32'(qs_sm[q]));
                chk("burst_cos_mag", 32'(q_cos_mag), 32'(qs_cm[q]));
                chk("burst_no_chroma", 32'(q_chroma), 32'd0);
                chk("burst_t_inst", 32'(t_burst), 32'd1);
            end
            step();
        end
        chk("burst_rise_clk", 32'(rise), 32'd78);
        chk("burst_len_clk", 32'(hi), 32'd63);

        // POST_BURST -> ACTIVE, chroma_valid two clocks after the state change
        active = 1'b1;
        step(); step();
        chk("chroma_early", 32'(d_chroma), 32'd0);
        step();
        chk("chroma_rise", 32'(d_chroma), 32'd1);
        chk("active_mag_nz", 32'(d_sin_mag != 8'd0), 32'd1);

        // Quadrant stepping with PHASE_INC=0x400000
        for (int w = 0; w < 8 && ((cyc - 2) & 32'd3) != 0; w++) step();
        for (int j = 0; j < 5; j++) begin
            chk("quad_sin_neg", 32'(q_sin_neg), 32'(qs_sn[j % 4]));
            chk("quad_cos_neg", 32'(q_cos_neg), 32'(qs_cn[j % 4] ^ par));
            chk("quad_sin_mag", 32'(q_sin_mag), 32'(qs_sm[j % 4]));
            step();
        end

        // Vector table on the 0x010000 instance
        for (int i = 0; i < 9; i++) begin
            for (int w = 0; w < 300 && int'((cyc - 2) & 32'd255) != tbl[i].n; w++) step();
            if (int'((cyc - 2) & 32'd255) != tbl[i].n) begin
                n_cmp++; n_bad++;
                $display("FAIL tbl_wait[%0d]: phase step %0d never reached", i, tbl[i].n);
            end
            chk("tbl_sin_mag", 32'(t_sin_mag), 32'(tbl[i].smag));
            chk("tbl_cos_mag", 32'(t_cos_mag), 32'(tbl[i].cmag));
            chk("tbl_sin_neg", 32'(t_sin_neg), 32'(tbl[i].sneg));
            chk("tbl_cos_neg", 32'(t_cos_neg), 32'(tbl[i].cneg ^ par));
            chk("tbl_chroma", 32'(t_chroma), 32'd1);
            step();
        end

        // Asynchronous reset mid-ACTIVE
        chk("pre_reset_chroma", 32'(d_chroma), 32'd1);
        #2 rst_n = 1'b0;
        #1;
        chk("async_rst_outputs", 32'(d_all), 32'd0);
        chk("async_rst_state", 32'(u_dut.state_reg), 32'd0);
        chk("async_rst_phase", 32'(u_dut.phase_reg), 32'd0);
        @(negedge clk);
        rst_n = 1'b1; par = 1'b0; active = 1'b0; color_en = 1'b0;
        step();

        // Colour disabled for a whole line: outputs silent, phase still advancing
        pulse_line();
        nz = 1'b0;
        for (int t = 0; t <= 250; t++) begin
            if (t == 150) active = 1'b1;
            if (t == 200) active = 1'b0;
            if (d_all != 20'd0) nz = 1'b1;
            if (t == 20 || t == 220)
                chk("coloroff_phase", 32'(u_dut.phase_reg), 32'((cyc * 32'(INC_D)) & 32'hFFFFFF));
            if (t == 230) ph0 = u_dut.phase_reg;
            if (t == 231) begin
                dph = u_dut.phase_reg - ph0;
                chk("coloroff_phase_step", 32'(dph), 32'(INC_D));
            end
            step();
        end
        chk("coloroff_silent", 32'(nz), 32'd0);
        chk("coloroff_end_idle", 32'(u_dut.state_reg), 32'd0);

        // line_start at cycle 30 of BURST aborts the line
        color_en = 1'b1;
        pulse_line();
        for (int t = 0; t < 105; t++) step();
        chk("abort_in_burst", 32'(d_burst), 32'd1);
        pulse_line();
        step();
        chk("abort_hold", 32'(d_burst), 32'd1);
        step();
        chk("abort_drop", 32'(d_burst), 32'd0);
        rise = 0;
        for (int t = 2; t <= 100; t++) begin
            if (d_burst && rise == 0) rise = t;
            step();
        end
        chk("abort_rerise", 32'(rise), 32'd78);

        // Two 256-clock lines: identical phase for both stepped instances
        pulse_line();
        for (int t = 0; t < 255; t++) begin
            if (t == 100) begin sa = q_sin_neg; ca = q_cos_neg; ta = t_cos_mag; end
            step();
        end
        pulse_line();
        for (int t = 0; t < 170; t++) begin
            if (t == 100) begin sb = q_sin_neg; cb = q_cos_neg; tbm = t_cos_mag; end
            if (t == 150) active = 1'b1;
            step();
        end
        chk("line_pair_sin_neg", 32'(sb), 32'(sa));
        chk("line_pair_cos_neg", 32'(cb), 32'(ca ^ PAL));
        chk("line_pair_cos_mag", 32'(tbm), 32'(ta));

        // line_start together with active falling: line_start wins
        chk("pre_tie_active", 32'(u_dut.state_reg), 32'd4);
        active = 1'b0;
        pulse_line();
        chk("tie_pre_burst", 32'(u_dut.state_reg), 32'd1);
        repeat (5) step();
        chk("tie_still_pre", 32'(u_dut.state_reg), 32'd1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/video_modulator_subcarrier_gen.md
VIDEO_MODULATOR_SUBCARRIER_GEN -- requirements
Module: video_modulator_subcarrier_gen

Interface
REQ-001 The block SHALL have parameter PHASE_INC, default 24'd2402192, the per-clock 24-bit phase increment (3.579545 MHz at 25 MHz clk).
REQ-002 The block SHALL have parameter BURST_START, default 10'd76, the clk count after line_start at which the colour burst begins.
REQ-003 The block SHALL have parameter BURST_LEN, default 10'd63, the burst length in clk cycles.
REQ-004 The block SHALL have port clk, input, 1, the single clock; all logic is in this domain.
REQ-005 The block SHALL have port rst_n, input, 1, the asynchronous active-low reset.
REQ-006 The block SHALL have port color_en, input, 1, which enables chroma; when low, all magnitude outputs are forced to 0.
REQ-007 The block SHALL have port line_start, input, 1, a single-cycle pulse at the start of each line (hsync leading edge).
REQ-008 The block SHALL have port active, input, 1, which is high during visible pixels.
REQ-009 The block SHALL have port sin_mag_8, output, 8, the |sin(phase)| magnitude that feeds a multiplier b-input.
REQ-010 The block SHALL have port cos_mag_8, output, 8, the |cos(phase)| magnitude that feeds a multiplier b-input.
REQ-011 The block SHALL have ports sin_neg and cos_neg, output, 1 each, the sign bits applied after the unsigned multiply.
REQ-012 The block SHALL have port burst, output, 1, which is high while the burst window is being output.
REQ-013 The block SHALL have port chroma_valid, output, 1, which is high while the sin/cos outputs are to be used for active video.

Function
REQ-014 The phase accumulator SHALL be 24 bits, SHALL add PHASE_INC every clk, SHALL wrap modulo 2^24, and SHALL run continuously regardless of color_en or state.
REQ-015 Phase bits [23:22] SHALL select the quadrant and bits [21:16] SHALL index a 64-entry quarter-wave ROM holding round(255*sin((i+0.5)*pi/128)).
REQ-016 Within each quadrant the sin index SHALL be direct in quadrants 0 and 2 and mirrored (63-i) in quadrants 1 and 3, and the cos index SHALL be the complement of the sin index.
REQ-017 sin_neg SHALL be high in quadrants 2 and 3, and cos_neg SHALL be high in quadrants 1 and 2.
REQ-018 Latency SHALL be exactly 2 clk: the phase register feeds the ROM-address/sign register, which feeds the output register; burst and chroma_valid SHALL be delayed to match.
REQ-019 The line FSM SHALL have states IDLE, PRE_BURST, BURST, POST_BURST and ACTIVE.
REQ-020 The line FSM SHALL move from any state to PRE_BURST on line_start and clear the 10-bit line counter to 0.
REQ-021 The FSM SHALL move from PRE_BURST to BURST when the counter equals BURST_START-1.
REQ-022 The FSM SHALL move from BURST to POST_BURST after BURST_LEN cycles in BURST.
REQ-023 The FSM SHALL move from POST_BURST to ACTIVE when active is high, and from ACTIVE to IDLE when active falls.
REQ-024 The line counter SHALL saturate at 1023 and SHALL NOT wrap.
REQ-025 The burst output SHALL be high only in BURST with color_en high; during burst the outputs SHALL carry burst phase (180 deg), i.e. sin_neg and cos_neg are inverted from the ROM values.
REQ-026 chroma_valid SHALL be high only in ACTIVE with color_en high, and outside BURST/ACTIVE both magnitudes SHALL be 0.
REQ-027 A line_start arriving in BURST or ACTIVE SHALL abort the current line immediately and restart at PRE_BURST.
REQ-028 A line_start coinciding with a falling edge on active SHALL be resolved in favour of line_start.

Reset
REQ-029 On rst_n low the block SHALL asynchronously clear the phase accumulator, the pipeline registers and the counter, and SHALL set the FSM to IDLE.
REQ-030 During and after reset, all outputs SHALL be 0 until the first line_start.
REQ-031 Reset deassertion SHALL be synchronised externally; the block SHALL need no internal synchroniser.

Configuration
REQ-032 With macro VIDEO_MODULATOR_PAL_SWITCH_EN defined, a line-parity flop SHALL toggle on each line_start (reset value 0), and cos_neg SHALL be inverted on odd lines, in both burst and active.
REQ-033 With VIDEO_MODULATOR_PAL_SWITCH_EN undefined, there SHALL be no parity flop and cos_neg SHALL follow REQ-017/REQ-025 only.

Verification
REQ-034 The bench SHALL check: rst_n low mid-ACTIVE -> all outputs 0 within the same cycle, FSM IDLE, phase 0.
REQ-035 The bench SHALL check: PHASE_INC=24'h400000 -> quadrant steps 0,1,2,3,0 on successive clocks; with output taken 2 clk later, sin_neg = 0,0,1,1 and cos_neg = 0,1,1,0.
REQ-036 The bench SHALL check: line_start, color_en=1 -> burst rises exactly 76+2 clk after the pulse and stays high for exactly 63 clk.
REQ-037 The bench SHALL check: color_en=0 for a whole line -> sin_mag_8, cos_mag_8, burst and chroma_valid stay 0, while the phase keeps advancing by PHASE_INC per clk.
REQ-038 The bench SHALL check: line_start pulsed at cycle 30 of BURST -> burst drops 2 clk later and re-rises 76+2 clk after the new pulse.
REQ-039 The bench SHALL check: with VIDEO_MODULATOR_PAL_SWITCH_EN, two consecutive lines at identical phase -> cos_neg is opposite between the lines and sin_neg is identical.
